// File: rtl/eth_tx_arb_pkg.sv
// Shared types and helpers for the Ethernet TX frame arbiter.
//   state_t        arbiter FSM states (ABORT/DRAIN only reachable with ETH_TX_ARB_WATCHDOG_EN)
//   ABORT_TDATA    data byte of the synthetic abort beat
//   onehot_to_idx  one-hot (up to 8 bits) to binary index
package eth_tx_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FWD,
    ST_GAP,
    ST_ABORT,
    ST_DRAIN
  } state_t;

  localparam logic [7:0] ABORT_TDATA = 8'h00;

  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++)
      if (oh[i]) idx = idx | 3'(i);
    return idx;
  endfunction

endpackage

// File: rtl/eth_tx_arb_if.sv
// AXI4-Stream bundle around the arbiter: N source streams in, one MAC stream out.
//   s_axis_*  per-source streams, source i data at [8i+7:8i]
//   m_axis_*  shared MAC TX stream
// Modports: slave = arbiter side, master = environment side (sources + MAC).
interface eth_tx_arb_if #(
  parameter int N = 4
);
  logic [N*8-1:0] s_axis_tdata;
  logic [N-1:0]   s_axis_tuser;
  logic [N-1:0]   s_axis_tlast;
  logic [N-1:0]   s_axis_tvalid;
  logic [N-1:0]   s_axis_tready;
  logic [7:0]     m_axis_tdata;
  logic           m_axis_tuser;
  logic           m_axis_tlast;
  logic           m_axis_tvalid;
  logic           m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tuser, s_axis_tlast, s_axis_tvalid,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid,
    input  m_axis_tready
  );

  modport master (
    output s_axis_tdata, s_axis_tuser, s_axis_tlast, s_axis_tvalid,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid,
    output m_axis_tready
  );
endinterface

// File: rtl/eth_tx_arb_pick.sv
// Combinational winner selection.
//   eligible       requesting and enabled sources
//   rr_ptr         round-robin search start index
//   priority_mode  0: search from rr_ptr, 1: search from index 0 (fixed priority)
//   winner         one-hot winner, 0 when nothing eligible
module eth_tx_arb_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] eligible,
  input  logic [2:0]   rr_ptr,
  input  logic         priority_mode,
  output logic [N-1:0] winner
);
  always_comb begin
    int   base;
    int   j;
    logic found;
    winner = '0;
    found  = 1'b0;
    base   = priority_mode ? 0 : int'(rr_ptr);
    for (int i = 0; i < N; i++) begin
      j = (base + i) % N;
      if (!found && eligible[j]) begin
        winner[j] = 1'b1;
        found     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-granular arbiter sharing one 8-bit AXI4-Stream Ethernet TX port among
// C_NUM_SOURCES sources. Frames never interleave; ifg_cycles extra idle cycles
// follow every frame.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   enable_mask     per-source enable, only looked at while arbitrating
//   priority_mode   0 round-robin, 1 fixed priority (index 0 highest)
//   ifg_cycles      extra idle cycles after each tlast beat
//   axis            source streams in / MAC stream out (eth_tx_arb_if.slave)
//   grant           registered one-hot grant, 0 when idle
//   stall_abort     one-cycle pulse when a stalled frame is aborted
// Build option ETH_TX_ARB_WATCHDOG_EN: a granted source that stays without
// tvalid for C_STALL_TIMEOUT cycles gets its frame closed with an errored
// tlast beat; the rest of that source frame is then drained and dropped.
module eth_tx_arbiter
  import eth_tx_arb_pkg::*;
#(
  parameter int C_NUM_SOURCES   = 4,
  parameter int C_STALL_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [C_NUM_SOURCES-1:0] enable_mask,
  input  logic                     priority_mode,
  input  logic [7:0]               ifg_cycles,
  eth_tx_arb_if.slave              axis,
  output logic [C_NUM_SOURCES-1:0] grant,
  output logic                     stall_abort
);
  localparam int N = C_NUM_SOURCES;

  state_t       state, state_nxt;
  logic [N-1:0] grant_nxt, winner, eligible;
  logic [2:0]   rr_ptr, rr_ptr_nxt, win_idx;
  logic [7:0]   gap_cnt, gap_nxt;
  logic         frame_end;
  logic [7:0]   sel_data;
  logic         sel_user, sel_last, sel_valid;

`ifdef ETH_TX_ARB_WATCHDOG_EN
  localparam int WDW = $clog2(C_STALL_TIMEOUT + 1);
  logic [WDW-1:0] wd_cnt, wd_nxt;
  logic           abort_q;
`endif

  assign eligible = axis.s_axis_tvalid & enable_mask;

  eth_tx_arb_pick #(.N(N)) u_pick (
    .eligible      (eligible),
    .rr_ptr        (rr_ptr),
    .priority_mode (priority_mode),
    .winner        (winner)
  );

  assign win_idx = onehot_to_idx(8'(winner));

  // Granted source's stream; all zero while grant is 0.
  always_comb begin
    sel_data  = '0;
    sel_user  = 1'b0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        sel_data  = axis.s_axis_tdata[i*8 +: 8];
        sel_user  = axis.s_axis_tuser[i];
        sel_last  = axis.s_axis_tlast[i];
        sel_valid = axis.s_axis_tvalid[i];
      end
    end
  end

  always_comb begin
    state_nxt          = state;
    grant_nxt          = grant;
    rr_ptr_nxt         = rr_ptr;
    gap_nxt            = gap_cnt;
    frame_end          = 1'b0;
    axis.m_axis_tdata  = '0;
    axis.m_axis_tuser  = 1'b0;
    axis.m_axis_tlast  = 1'b0;
    axis.m_axis_tvalid = 1'b0;
    axis.s_axis_tready = '0;
`ifdef ETH_TX_ARB_WATCHDOG_EN
    wd_nxt             = wd_cnt;
`endif
    unique case (state)
      ST_IDLE: begin
        if (|eligible) begin
          grant_nxt  = winner;
          // pointer moves in both modes so a switch to RR continues fairly
          rr_ptr_nxt = (win_idx == 3'(N - 1)) ? 3'd0 : win_idx + 3'd1;
          state_nxt  = ST_FWD;
`ifdef ETH_TX_ARB_WATCHDOG_EN
          wd_nxt     = '0;
`endif
        end
      end
      ST_FWD: begin
        axis.m_axis_tdata  = sel_data;
        axis.m_axis_tuser  = sel_user;
        axis.m_axis_tlast  = sel_last;
        axis.m_axis_tvalid = sel_valid;
        axis.s_axis_tready = grant & {N{axis.m_axis_tready}};
        if (sel_valid && sel_last && axis.m_axis_tready)
          frame_end = 1'b1;
`ifdef ETH_TX_ARB_WATCHDOG_EN
        // only a source without data counts as stalled, MAC backpressure does not
        else if (sel_valid)
          wd_nxt = '0;
        else begin
          wd_nxt = wd_cnt + 1'b1;
          if (wd_nxt == WDW'(C_STALL_TIMEOUT))
            state_nxt = ST_ABORT;
        end
`endif
      end
      ST_GAP: begin
        if (gap_cnt == 8'd1) state_nxt = ST_IDLE;
        else                 gap_nxt   = gap_cnt - 8'd1;
      end
`ifdef ETH_TX_ARB_WATCHDOG_EN
      ST_ABORT: begin
        axis.m_axis_tdata  = ABORT_TDATA;
        axis.m_axis_tuser  = 1'b1;
        axis.m_axis_tlast  = 1'b1;
        axis.m_axis_tvalid = 1'b1;
        if (axis.m_axis_tready) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // swallow the rest of the source frame; MAC already saw tlast
        axis.s_axis_tready = grant;
        if (sel_valid && sel_last) frame_end = 1'b1;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase

    if (frame_end) begin
      grant_nxt = '0;
      if (ifg_cycles == 8'd0) state_nxt = ST_IDLE;
      else begin
        state_nxt = ST_GAP;
        gap_nxt   = ifg_cycles;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      grant   <= '0;
      rr_ptr  <= '0;
      gap_cnt <= '0;
`ifdef ETH_TX_ARB_WATCHDOG_EN
      wd_cnt  <= '0;
      abort_q <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      rr_ptr  <= rr_ptr_nxt;
      gap_cnt <= gap_nxt;
`ifdef ETH_TX_ARB_WATCHDOG_EN
      wd_cnt  <= wd_nxt;
      abort_q <= (state == ST_FWD) && (state_nxt == ST_ABORT);
`endif
    end
  end

`ifdef ETH_TX_ARB_WATCHDOG_EN
  assign stall_abort = abort_q;
`else
  assign stall_abort = 1'b0;
`endif

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: a vector table for arbitration decisions
// plus hand-written sequences for ordering, starvation, inter-frame gap,
// backpressure, watchdog abort and mid-frame reset.
`timescale 1ns/1ps
module tb_eth_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] enable_mask;
  logic         priority_mode;
  logic [7:0]   ifg_cycles;
  logic [N-1:0] grant;
  logic         stall_abort;

  always #5 clk = ~clk;

  eth_tx_arb_if #(.N(N)) bus ();

  eth_tx_arbiter #(.C_NUM_SOURCES(N), .C_STALL_TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable_mask   (enable_mask),
    .priority_mode (priority_mode),
    .ifg_cycles    (ifg_cycles),
    .axis          (bus),
    .grant         (grant),
    .stall_abort   (stall_abort)
  );

  // ---- source model: byte k of source i's frame is sbase[i]+k ----
  int unsigned  cnt[N] = '{default: 0};
  int unsigned  ofs[N] = '{default: 0};
  int unsigned  slen[N] = '{default: 0};
  int unsigned  stall_at[N] = '{default: 0};
  int unsigned  pos[N];
  logic [7:0]   sbase[N] = '{default: 8'h00};
  logic [N-1:0] reload = '0, stall = '0, uflag = '0;

  always_comb begin
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = '0;
    bus.s_axis_tlast  = '0;
    bus.s_axis_tuser  = '0;
    for (int i = 0; i < N; i++) begin
      pos[i] = cnt[i] - ofs[i];
      if (reload[i] && slen[i] != 0) pos[i] = pos[i] % slen[i];
      bus.s_axis_tdata[i*8 +: 8] = sbase[i] + 8'(pos[i]);
      bus.s_axis_tvalid[i] = (pos[i] < slen[i]) && !(stall[i] && pos[i] == stall_at[i]);
      bus.s_axis_tlast[i]  = (pos[i] + 1 == slen[i]);
      bus.s_axis_tuser[i]  = uflag[i] && (pos[i] + 1 == slen[i]);
    end
  end

  always @(posedge clk)
    for (int i = 0; i < N; i++)
      if (bus.s_axis_tvalid[i] && bus.s_axis_tready[i]) cnt[i] <= cnt[i] + 1;

  // ---- output monitor ----
  typedef struct {
    int         src;
    logic [7:0] d;
    logic       u, l, f;
    int         cyc;
  } beat_t;
  beat_t lg[$];
  int    abort_cyc[$];
  int    cyc = 0;
  logic  in_frame = 1'b0;

  always @(posedge clk) begin
    beat_t b;
    cyc <= cyc + 1;
    if (stall_abort) abort_cyc.push_back(cyc);
    if (bus.m_axis_tvalid && bus.m_axis_tready) begin
      b.src = -1;
      for (int i = 0; i < N; i++) if (grant[i]) b.src = i;
      b.d = bus.m_axis_tdata; b.u = bus.m_axis_tuser; b.l = bus.m_axis_tlast;
      b.f = !in_frame; b.cyc = cyc;
      lg.push_back(b);
      in_frame <= !bus.m_axis_tlast;
    end
    if (rst) in_frame <= 1'b0;
  end

  // ---- checking helpers ----
  int n_cmp = 0, n_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic tick_bp(int n);
    repeat (n) begin
      @(posedge clk); #2;
      bus.m_axis_tready = 1'($urandom_range(0, 1));
    end
  endtask

  function automatic int nbeats(int s);
    int c = 0;
    foreach (lg[k]) if (lg[k].src == s) c++;
    return c;
  endfunction

  task automatic wait_beats(string nm, int s, int n, int budget, bit bp);
    int k = 0;
    while (nbeats(s) < n && k < budget) begin
      if (bp) tick_bp(1); else tick(1);
      k++;
    end
    n_cmp++;
    if (nbeats(s) < n) begin
      n_bad++;
      $display("FAIL %s: timeout with %0d beats from source %0d, expected %0d", nm, nbeats(s), s, n);
    end
  endtask

  task automatic load(int i, int len, logic [7:0] base);
    ofs[i] = cnt[i]; slen[i] = len; sbase[i] = base;
  endtask

  task automatic reset_all();
    for (int i = 0; i < N; i++) begin slen[i] = 0; ofs[i] = cnt[i]; end
    reload = '0; stall = '0; uflag = '0;
    bus.m_axis_tready = 1'b1;
    rst = 1'b1; tick(2); rst = 1'b0;
    lg.delete(); abort_cyc.delete();
  endtask

  // ---- arbitration vectors: single-beat frames, ifg 0, pointer carried across rows ----
  typedef struct {
    logic         mode;
    logic [N-1:0] en, req, exp;
  } vec_t;
  vec_t tbl[12];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sw, first3, n1first, bad, k, last1, t10;

    tbl = '{
      '{1'b0, 4'hF, 4'hF, 4'h1}, '{1'b0, 4'hF, 4'hF, 4'h2}, '{1'b0, 4'hF, 4'h3, 4'h1},
      '{1'b0, 4'hD, 4'hA, 4'h8}, '{1'b1, 4'hF, 4'hC, 4'h4}, '{1'b1, 4'hF, 4'hA, 4'h2},
      '{1'b0, 4'hF, 4'hB, 4'h8}, '{1'b0, 4'hF, 4'h8, 4'h8}, '{1'b0, 4'h7, 4'h8, 4'h0},
      '{1'b1, 4'hE, 4'hF, 4'h2}, '{1'b0, 4'hF, 4'h6, 4'h4}, '{1'b0, 4'hF, 4'h7, 4'h1}
    };

    // reset state, with every source requesting while rst is held
    rst = 1'b1; enable_mask = '1; priority_mode = 1'b0; ifg_cycles = 8'd0;
    bus.m_axis_tready = 1'b1;
    for (int i = 0; i < N; i++) load(i, 3, 8'(8'hA0 + 16 * i));
    tick(3);
    chk("rst grant", grant, 0);
    chk("rst tvalid", bus.m_axis_tvalid, 0);
    chk("rst tdata", bus.m_axis_tdata, 0);
    chk("rst s_tready", bus.s_axis_tready, 0);
    chk("rst stall_abort", stall_abort, 0);

    // round-robin order 0,1,2,3, one idle cycle between frames
    rst = 1'b0;
    wait_beats("rr4 done", 3, 3, 80, 0);
    chk("rr4 beat count", lg.size(), 12);
    if (lg.size() == 12) begin
      for (int b = 0; b < 12; b++) begin
        chk($sformatf("rr4 src[%0d]", b), lg[b].src, b / 3);
        chk($sformatf("rr4 data[%0d]", b), lg[b].d, 8'hA0 + 16 * (b / 3) + (b % 3));
      end
      for (int f = 1; f < 4; f++)
        chk($sformatf("rr4 gap[%0d]", f), lg[3*f].cyc - lg[3*f-1].cyc, 2);
    end

    // table of arbitration decisions
    reset_all();
    uflag = 4'b0101;
    for (int v = 0; v < 12; v++) begin
      int widx;
      for (int i = 0; i < N; i++) begin
        ofs[i] = cnt[i]; slen[i] = tbl[v].req[i] ? 1 : 0; sbase[i] = 8'(16 * i + v);
      end
      priority_mode = tbl[v].mode; enable_mask = tbl[v].en;
      tick(1);
      widx = 0;
      for (int i = 0; i < N; i++) if (tbl[v].exp[i]) widx = i;
      chk($sformatf("vec%0d grant", v), grant, tbl[v].exp);
      chk($sformatf("vec%0d tvalid", v), bus.m_axis_tvalid, |tbl[v].exp);
      chk($sformatf("vec%0d s_tready", v), bus.s_axis_tready, tbl[v].exp);
      if (tbl[v].exp != 0) begin
        chk($sformatf("vec%0d tdata", v), bus.m_axis_tdata, 16 * widx + v);
        chk($sformatf("vec%0d tuser", v), bus.m_axis_tuser, uflag[widx]);
        chk($sformatf("vec%0d tlast", v), bus.m_axis_tlast, 1);
      end
      tick(1);
    end
    uflag = '0; enable_mask = '1;

    // fixed priority starves source 3; switching to RR serves it next
    reset_all();
    priority_mode = 1'b1;
    load(1, 2, 8'h50); reload[1] = 1'b1;
    load(3, 2, 8'h70);
    tick(30);
    chk("fixed src3 starved", nbeats(3), 0);
    chk("fixed src1 served", nbeats(1) >= 10, 1);
    priority_mode = 1'b0;
    sw = cyc;
    wait_beats("rr src3 served", 3, 2, 20, 0);
    first3 = 0; n1first = 0;
    foreach (lg[b]) if (lg[b].src == 3 && first3 == 0) first3 = lg[b].cyc;
    foreach (lg[b]) if (lg[b].src == 1 && lg[b].f && lg[b].cyc > sw && lg[b].cyc < first3) n1first++;
    chk("rr src1 frames before src3", n1first, 0);

    // ifg 12 between back-to-back 64-byte frames
    reset_all();
    ifg_cycles = 8'd12;
    load(0, 64, 8'h00); reload[0] = 1'b1;
    wait_beats("ifg two frames", 0, 66, 400, 0);
    if (lg.size() >= 66) begin
      chk("ifg tlast on beat 63", lg[63].l, 1);
      chk("ifg no tlast on beat 62", lg[62].l, 0);
      chk("ifg next frame first byte", lg[64].d, 0);
      chk("ifg gap cycles", lg[64].cyc - lg[63].cyc, 14);
    end

    // random backpressure; source 1 disabled mid-frame
    reset_all();
    ifg_cycles = 8'd3;
    load(1, 20, 8'h40); reload[1] = 1'b1;
    load(2, 10, 8'h80);
    wait_beats("bp src1 started", 1, 5, 200, 1);
    enable_mask[1] = 1'b0;
    wait_beats("bp src2 done", 2, 10, 400, 1);
    tick_bp(40);
    bus.m_axis_tready = 1'b1;
    bad = 0; k = 0; last1 = 0;
    foreach (lg[b]) if (lg[b].src == 1) begin
      if (lg[b].d != 8'(8'h40 + k)) bad++;
      last1 = lg[b].l;
      k++;
    end
    chk("bp src1 beats", k, 20);
    chk("bp src1 byte errors", bad, 0);
    chk("bp src1 ends with tlast", last1, 1);
    chk("bp src2 beats", nbeats(2), 10);
    enable_mask = '1;

    // stalled source: watchdog abort, or indefinite wait without it
    reset_all();
    ifg_cycles = 8'd0;
    load(2, 60, 8'h00); stall_at[2] = 10; stall[2] = 1'b1;
    wait_beats("stall first 10", 2, 10, 100, 0);
`ifdef ETH_TX_ARB_WATCHDOG_EN
    t10 = lg[lg.size() - 1].cyc;
    tick(24);
    chk("wd beats incl abort", nbeats(2), 11);
    if (lg.size() == 11) begin
      chk("wd abort tdata", lg[10].d, 8'h00);
      chk("wd abort tuser", lg[10].u, 1);
      chk("wd abort tlast", lg[10].l, 1);
      chk("wd abort latency", lg[10].cyc - t10, 17);
      chk("wd pulse count", abort_cyc.size(), 1);
      if (abort_cyc.size() == 1) chk("wd pulse cycle", abort_cyc[0], lg[10].cyc);
    end
    stall[2] = 1'b0;
    tick(80);
    chk("wd source drained", pos[2], 60);
    chk("wd no beats after abort", nbeats(2), 11);
    chk("wd grant released", grant, 0);
`else
    t10 = 0;
    tick(40);
    chk("nowd no abort pulse", abort_cyc.size(), t10);
    chk("nowd grant held", grant, 4'b0100);
    chk("nowd tvalid low", bus.m_axis_tvalid, 0);
    stall[2] = 1'b0;
    wait_beats("nowd frame done", 2, 60, 100, 0);
    if (lg.size() == 60) chk("nowd tlast", lg[59].l, 1);
`endif

    // reset mid-frame; arbitration restarts from index 0
    reset_all();
    load(2, 10, 8'h30);
    wait_beats("midrst started", 2, 3, 50, 0);
    chk("midrst grant before", grant, 4'b0100);
    rst = 1'b1;
    load(0, 4, 8'h00); load(1, 4, 8'h10); load(3, 4, 8'h90);
    tick(1);
    rst = 1'b0;
    chk("midrst grant", grant, 0);
    chk("midrst tvalid", bus.m_axis_tvalid, 0);
    chk("midrst tlast", bus.m_axis_tlast, 0);
    chk("midrst s_tready", bus.s_axis_tready, 0);
    tick(1);
    chk("midrst regrant idx0", grant, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
